// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Responder side of the byte-lane data-memory interface used by the MEM
// stage. One request is accepted at a time. After WAIT_STATES extra cycles
// the access is performed on four 8-bit banks. The responder then returns a
// single-cycle ack with registered read data. While a request is in flight,
// o_busy is high so the hazard logic can stall the pipeline.
//
// Optional feature (compile-time macro DMEM_MMIO_EN):
//   - The top word (2^ADDR_WIDTH-1) maps to the o_io_out register.
//   - The word below it (2^ADDR_WIDTH-2) reads a free-running cycle counter.
//   Without the macro, both words are ordinary memory and o_io_out is 0.
//
// Ports:
//   i_clk     system clock, rising edge
//   i_rst     asynchronous active-high reset
//   i_en_n    active-low enable; when high, all state and memory hold
//   i_req     request strobe, sampled only while idle
//   i_we      per-lane write enables (bit i selects i_wdata[8i+7:8i])
//   i_re      per-lane read enables
//   i_addr    word address
//   i_wdata   lane-aligned write data
//   o_ack     one-cycle completion pulse (stretched while i_en_n is high)
//   o_rdata   registered read data, valid while o_ack is high
//   o_busy    high from acceptance through the ack cycle
//   o_io_out  memory-mapped output register (0 without DMEM_MMIO_EN)
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 6,
  parameter int WAIT_STATES = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en_n,
  input  logic                  i_req,
  input  logic [3:0]            i_we,
  input  logic [3:0]            i_re,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_ack,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_busy,
  output logic [DATA_WIDTH-1:0] o_io_out
);

  localparam int LANES = 4;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  // The wait counter is loaded with WAIT_STATES-1 on acceptance. It reaches
  // zero on the last wait cycle.
  localparam logic [2:0] CNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [2:0]            r_cnt;
  logic [2:0]            w_cnt_next;
  logic                  w_accept;
  logic                  w_access;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_we;
  logic [3:0]            r_re;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic                  r_ack;
  logic                  r_busy;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic [ADDR_WIDTH-1:0] w_acc_addr;
  logic [3:0]            w_acc_we;
  logic [3:0]            w_acc_re;
  logic [DATA_WIDTH-1:0] w_acc_wdata;

  logic [7:0]            r_bank [LANES][DEPTH];
  logic [DATA_WIDTH-1:0] w_bank_word;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [DATA_WIDTH-1:0] w_rd_masked;
  logic                  w_bank_wr;

  // Next-state logic. The access happens at the edge that enters DONE.
  // With zero wait states, that edge is the acceptance edge itself.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_accept   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_req && ((i_we | i_re) != 4'b0000)) begin
          w_accept = 1'b1;
          if (WAIT_STATES == 0) begin
            w_next = S_DONE;
          end else begin
            w_next     = S_WAIT;
            w_cnt_next = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 3'd0) begin
          w_next = S_DONE;
        end else begin
          w_cnt_next = r_cnt - 3'd1;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    w_access = (w_next == S_DONE);
  end

  // During acceptance, the request registers are not yet loaded. In that
  // case the access (zero wait states only) uses the live inputs. Otherwise
  // it uses the latched copy, so later input changes cannot disturb the
  // request in flight.
  always_comb begin
    w_acc_addr  = r_addr;
    w_acc_we    = r_we;
    w_acc_re    = r_re;
    w_acc_wdata = r_wdata;
    if (r_state == S_IDLE) begin
      w_acc_addr  = i_addr;
      w_acc_we    = i_we;
      w_acc_re    = i_re;
      w_acc_wdata = i_wdata;
    end
  end

  // Gather the addressed word from the four banks.
  always_comb begin
    w_bank_word = '0;
    for (int l = 0; l < LANES; l++) begin
      w_bank_word[8*l +: 8] = r_bank[l][w_acc_addr];
    end
  end

`ifdef DMEM_MMIO_EN
  localparam logic [ADDR_WIDTH-1:0] IO_ADDR  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] CNT_ADDR = ADDR_WIDTH'(DEPTH - 2);

  logic                  w_is_io;
  logic                  w_is_cnt;
  logic [DATA_WIDTH-1:0] r_io_out;
  logic [DATA_WIDTH-1:0] r_cycles;

  assign w_is_io   = (w_acc_addr == IO_ADDR);
  assign w_is_cnt  = (w_acc_addr == CNT_ADDR);
  assign w_bank_wr = !(w_is_io || w_is_cnt);
  assign o_io_out  = r_io_out;

  // The MMIO words shadow the banks. Writes to the counter word are dropped.
  always_comb begin
    w_rd_word = w_bank_word;
    if (w_is_io) begin
      w_rd_word = r_io_out;
    end else if (w_is_cnt) begin
      w_rd_word = r_cycles;
    end
  end

  // The cycle counter runs whenever the block is enabled. The IO register
  // takes only the enabled lanes of a write to its word.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cycles <= '0;
      r_io_out <= '0;
    end else if (!i_en_n) begin
      r_cycles <= r_cycles + DATA_WIDTH'(1);
      if (w_access && w_is_io) begin
        for (int l = 0; l < LANES; l++) begin
          if (w_acc_we[l]) begin
            r_io_out[8*l +: 8] <= w_acc_wdata[8*l +: 8];
          end
        end
      end
    end
  end
`else
  assign w_bank_wr = 1'b1;
  assign w_rd_word = w_bank_word;
  assign o_io_out  = '0;
`endif

  // Lanes that are not read return zero.
  always_comb begin
    w_rd_masked = '0;
    for (int l = 0; l < LANES; l++) begin
      if (w_acc_re[l]) begin
        w_rd_masked[8*l +: 8] = w_rd_word[8*l +: 8];
      end
    end
  end

  // Control and output registers. ack and busy are registered copies of the
  // next state, so no input reaches an output combinationally. i_en_n freezes
  // everything, which also stretches an ack in progress.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_we    <= '0;
      r_re    <= '0;
      r_wdata <= '0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_rdata <= '0;
    end else if (!i_en_n) begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_ack   <= (w_next == S_DONE);
      r_busy  <= (w_next != S_IDLE);
      if (w_accept) begin
        r_addr  <= i_addr;
        r_we    <= i_we;
        r_re    <= i_re;
        r_wdata <= i_wdata;
      end
      if (w_access) begin
        r_rdata <= w_rd_masked;
      end
    end
  end

  // Bank storage. Reset clears every word, which discards any pending write.
  // Reads above sample the old contents, so the same edge gives
  // read-before-write behaviour.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int l = 0; l < LANES; l++) begin
        for (int w = 0; w < DEPTH; w++) begin
          r_bank[l][w] <= 8'h00;
        end
      end
    end else if (!i_en_n && w_access && w_bank_wr) begin
      for (int l = 0; l < LANES; l++) begin
        if (w_acc_we[l]) begin
          r_bank[l][w_acc_addr] <= w_acc_wdata[8*l +: 8];
        end
      end
    end
  end

  assign o_ack   = r_ack;
  assign o_busy  = r_busy;
  assign o_rdata = r_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed bench for dmem_responder with WAIT_STATES=1. Each request pushes
// its expected read data onto a scoreboard queue. The entry is popped and
// compared when the ack appears.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int WS = 1;

  logic        clk;
  logic        rst;
  logic        enN;
  logic        req;
  logic [3:0]  we;
  logic [3:0]  re;
  logic [5:0]  addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        busy;
  logic [31:0] ioOut;

  int          nChecks;
  int          nErrors;
  logic [31:0] sbQueue [$];
  logic [31:0] lastRdata;

  dmem_responder #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (6),
    .WAIT_STATES(WS)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_en_n  (enN),
    .i_req   (req),
    .i_we    (we),
    .i_re    (re),
    .i_addr  (addr),
    .i_wdata (wdata),
    .o_ack   (ack),
    .o_rdata (rdata),
    .o_busy  (busy),
    .o_io_out(ioOut)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    assert (observed === expected)
    else begin
      nErrors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Issue one request and follow it to completion. The task is entered and
  // left 1 time unit after a rising edge. The inputs are scrambled after
  // acceptance to show that the latched copy is what gets used.
  task automatic applyStimulus(input string tag, input logic [3:0] sWe,
                               input logic [3:0] sRe, input logic [5:0] sAddr,
                               input logic [31:0] sWdata, input logic [31:0] expRdata,
                               input bit checkData);
    int          cycles;
    logic [31:0] expected;
    if (checkData) sbQueue.push_back(expRdata);
    req   = 1'b1;
    we    = sWe;
    re    = sRe;
    addr  = sAddr;
    wdata = sWdata;
    @(posedge clk);
    #1;
    req   = 1'b0;
    we    = ~sWe;
    re    = ~sRe;
    addr  = ~sAddr;
    wdata = ~sWdata;
    checkOutput({tag, "_busyRise"}, 32'(busy), 32'd1);
    cycles = 0;
    while (ack !== 1'b1 && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    checkOutput({tag, "_latency"}, 32'(cycles), 32'(WS));
    checkOutput({tag, "_busyAtAck"}, 32'(busy), 32'd1);
    lastRdata = rdata;
    if (checkData) begin
      if (sbQueue.size() > 0) expected = sbQueue.pop_front();
      else expected = 32'hFFFF_FFFF;
      checkOutput({tag, "_rdata"}, rdata, expected);
    end
    @(posedge clk);
    #1;
    checkOutput({tag, "_ackFall"}, 32'(ack), 32'd0);
    checkOutput({tag, "_busyFall"}, 32'(busy), 32'd0);
    we = 4'h0;
    re = 4'h0;
  endtask

  logic [31:0] model [64];
  logic [31:0] firstCnt;

  initial begin
    nChecks = 0;
    nErrors = 0;
    rst     = 1'b1;
    enN     = 1'b0;
    req     = 1'b0;
    we      = 4'h0;
    re      = 4'h0;
    addr    = '0;
    wdata   = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_ack", 32'(ack), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_rdata", rdata, 32'd0);
    checkOutput("reset_io", ioOut, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] basic write/read");
    applyStimulus("wr5", 4'hF, 4'h0, 6'd5, 32'hDEAD_BEEF, 32'h0, 1'b1);
    applyStimulus("rd5", 4'h0, 4'hF, 6'd5, 32'h0, 32'hDEAD_BEEF, 1'b1);

    $display("[TB] byte lanes");
    applyStimulus("lane_wrF", 4'hF, 4'h0, 6'd7, 32'h1122_3344, 32'h0, 1'b1);
    applyStimulus("lane_wr8", 4'h8, 4'h0, 6'd7, 32'hAA00_0000, 32'h0, 1'b1);
    applyStimulus("lane_rd", 4'h0, 4'hA, 6'd7, 32'h0, 32'hAA00_3300, 1'b1);

    $display("[TB] read-before-write");
    applyStimulus("rbw_init", 4'hF, 4'h0, 6'd10, 32'h1, 32'h0, 1'b1);
    applyStimulus("rbw_rw", 4'hF, 4'hF, 6'd10, 32'h2, 32'h1, 1'b1);
    applyStimulus("rbw_rd", 4'h0, 4'hF, 6'd10, 32'h0, 32'h2, 1'b1);

    $display("[TB] request without strobes");
    req = 1'b1;
    we  = 4'h0;
    re  = 4'h0;
    @(posedge clk);
    #1;
    checkOutput("nostrobe_busy1", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("nostrobe_busy2", 32'(busy), 32'd0);
    checkOutput("nostrobe_ack", 32'(ack), 32'd0);
    req = 1'b0;

    $display("[TB] enable stall during ack");
    applyStimulus("stall_init", 4'hF, 4'h0, 6'd20, 32'hA5A5_A5A5, 32'h0, 1'b1);
    req   = 1'b1;
    we    = 4'hF;
    re    = 4'hF;
    addr  = 6'd20;
    wdata = 32'h5A5A_5A5A;
    @(posedge clk);
    #1;
    req = 1'b0;
    we  = 4'h0;
    re  = 4'h0;
    begin : stallWait
      int cycles;
      cycles = 0;
      while (ack !== 1'b1 && cycles < 20) begin
        @(posedge clk);
        #1;
        cycles++;
      end
      checkOutput("stall_latency", 32'(cycles), 32'(WS));
    end
    checkOutput("stall_rdata0", rdata, 32'hA5A5_A5A5);
    enN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("stall_ack%0d", i), 32'(ack), 32'd1);
      checkOutput($sformatf("stall_rdata%0d", i + 1), rdata, 32'hA5A5_A5A5);
    end
    enN = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("stall_ackEnd", 32'(ack), 32'd0);
    checkOutput("stall_busyEnd", 32'(busy), 32'd0);
    applyStimulus("stall_rd", 4'h0, 4'hF, 6'd20, 32'h0, 32'h5A5A_5A5A, 1'b1);

    $display("[TB] reset during wait");
    req   = 1'b1;
    we    = 4'hF;
    re    = 4'h0;
    addr  = 6'd9;
    wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    req = 1'b0;
    we  = 4'h0;
    checkOutput("rstmid_busyBefore", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rstmid_busy", 32'(busy), 32'd0);
    checkOutput("rstmid_ack", 32'(ack), 32'd0);
    checkOutput("rstmid_rdata", rdata, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus("rstmid_rd9", 4'h0, 4'hF, 6'd9, 32'h0, 32'h0, 1'b1);
    applyStimulus("rstmid_rd5", 4'h0, 4'hF, 6'd5, 32'h0, 32'h0, 1'b1);

`ifdef DMEM_MMIO_EN
    $display("[TB] mmio words");
    applyStimulus("mmio_wr63", 4'h1, 4'h0, 6'd63, 32'h5A, 32'h0, 1'b1);
    checkOutput("mmio_io", ioOut, 32'h5A);
    applyStimulus("mmio_rd63", 4'h0, 4'hF, 6'd63, 32'h0, 32'h5A, 1'b1);
    applyStimulus("mmio_cnt1", 4'h0, 4'hF, 6'd62, 32'h0, 32'h0, 1'b0);
    firstCnt = lastRdata;
    repeat (7) @(posedge clk);
    #1;
    applyStimulus("mmio_cnt2", 4'h0, 4'hF, 6'd62, 32'h0, 32'h0, 1'b0);
    checkOutput("mmio_cntDelta", lastRdata - firstCnt, 32'd10);
`else
    $display("[TB] top words as plain memory");
    applyStimulus("plain_wr63", 4'h1, 4'h0, 6'd63, 32'h5A, 32'h0, 1'b1);
    checkOutput("plain_io", ioOut, 32'h0);
    applyStimulus("plain_rd63", 4'h0, 4'hF, 6'd63, 32'h0, 32'h5A, 1'b1);
    applyStimulus("plain_wr62", 4'hF, 4'h0, 6'd62, 32'h1234_5678, 32'h0, 1'b1);
    applyStimulus("plain_rd62", 4'h0, 4'hF, 6'd62, 32'h0, 32'h1234_5678, 1'b1);
`endif

    $display("[TB] random lane traffic");
    for (int a = 0; a < 64; a++) model[a] = 32'h0;
    for (int n = 0; n < 16; n++) begin
      logic [3:0]  rWe;
      logic [3:0]  rRe;
      logic [5:0]  rAddr;
      logic [31:0] rData;
      logic [31:0] exp;
      rAddr = 6'(32 + $urandom_range(0, 3));
      rWe   = 4'($urandom_range(0, 15));
      rRe   = 4'($urandom_range(1, 15));
      rData = $urandom;
      exp   = 32'h0;
      for (int l = 0; l < 4; l++) begin
        if (rRe[l]) exp[8*l +: 8] = model[rAddr][8*l +: 8];
      end
      for (int l = 0; l < 4; l++) begin
        if (rWe[l]) model[rAddr][8*l +: 8] = rData[8*l +: 8];
      end
      applyStimulus($sformatf("rand%0d", n), rWe, rRe, rAddr, rData, exp, 1'b1);
    end

    checkOutput("sb_empty", 32'(sbQueue.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
